// File: rtl/param_modn_counter.sv
// Modulo-MODULUS up/down counter with enable, clear, range-checked load, tc cascade and one-shot stop.
// Define MODN_WRAP_COUNT_EN to add the saturating wrap_cnt statistic output.
module param_modn_counter #(
    parameter int WIDTH      = 4,
    parameter int MODULUS    = 10,
    parameter int RESET_VAL  = 0,
    parameter int WCNT_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             done,
    output logic             load_err,
    output logic             state_dbg
`ifdef MODN_WRAP_COUNT_EN
    ,
    output logic [WCNT_WIDTH-1:0] wrap_cnt
`endif
);

    typedef enum logic [0:0] {
        COUNT = 1'b0,
        DONE  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);
    // One extra bit so MODULUS == 2**WIDTH is representable for the range check.
    localparam logic [WIDTH:0]   LIMIT   = (WIDTH + 1)'(MODULUS);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("param_modn_counter: MODULUS out of range for WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("param_modn_counter: RESET_VAL must be below MODULUS");
    end
    if (WCNT_WIDTH < 1) begin : g_bad_wcnt_width
        $error("param_modn_counter: WCNT_WIDTH must be at least 1");
    end

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             wrap_nxt;
    logic             done_nxt;
    logic             load_err_nxt;
    logic [WIDTH-1:0] terminal;
    logic             at_term;
    logic             load_ok;

    assign terminal  = up ? MAX_VAL : '0;
    assign at_term   = (out == terminal);
    assign load_ok   = ({1'b0, load_val} < LIMIT);
    assign tc        = en & (state == COUNT) & at_term;
    assign state_dbg = state;

    // Priority: clr > load > count > hold. Pulses default low so they last one cycle.
    always_comb begin
        out_nxt      = out;
        state_nxt    = state;
        wrap_nxt     = 1'b0;
        load_err_nxt = 1'b0;
        if (clr) begin
            out_nxt   = RST_V;
            state_nxt = COUNT;
        end else if (load) begin
            out_nxt      = load_ok ? load_val : MAX_VAL;
            load_err_nxt = ~load_ok;
            state_nxt    = COUNT;
        end else if (en && state == COUNT) begin
            if (!at_term) begin
                out_nxt = up ? out + 1'b1 : out - 1'b1;
            end else if (!oneshot) begin
                out_nxt  = up ? '0 : MAX_VAL;
                wrap_nxt = 1'b1;
            end else begin
                state_nxt = DONE;
            end
        end
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out      <= RST_V;
            state    <= COUNT;
            wrap     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            out      <= out_nxt;
            state    <= state_nxt;
            wrap     <= wrap_nxt;
            done     <= done_nxt;
            load_err <= load_err_nxt;
        end
    end

`ifdef MODN_WRAP_COUNT_EN
    localparam logic [WCNT_WIDTH-1:0] WCNT_MAX = '1;

    // Counts the same event that raises wrap, so it tracks the pulse exactly; load leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_cnt <= '0;
        end else if (clr) begin
            wrap_cnt <= '0;
        end else if (wrap_nxt && wrap_cnt != WCNT_MAX) begin
            wrap_cnt <= wrap_cnt + 1'b1;
        end
    end
`endif

endmodule
